// File: rtl/sram_req_queue_if.sv
// sram_req_queue_if: bus bundle for the SRAM request queue.
//   Host side:       req_valid/req_ready/req_rw/req_addr/req_wdata, rsp_valid/rsp_rdata
//   Controller side: mem/rw/addr/data_f2s out, sram_ready/sram_rdata in
// Modports:
//   slave  - the request queue itself
//   master - whatever drives the host requests and models the controller
interface sram_req_queue_if #(
  parameter int AW = 18,
  parameter int DW = 16
);
  logic          req_valid;
  logic          req_ready;
  logic          req_rw;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          mem;
  logic          rw;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_f2s;
  logic          sram_ready;
  logic [DW-1:0] sram_rdata;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, sram_ready, sram_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem, rw, addr, data_f2s
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, sram_ready, sram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem, rw, addr, data_f2s
  );
endinterface

// File: rtl/sram_req_queue.sv
// sram_req_queue: request FIFO in front of the single-port SRAM controller.
// Buffers host read/write requests and issues them one at a time to the
// controller (mem strobe, rw, addr, data_f2s) when it reports ready. Read
// data is captured RD_LAT cycles after the strobe and returned in order as a
// one-cycle rsp_valid pulse.
// Ports:
//   clk      - system clock, posedge
//   reset_n  - asynchronous reset, active low
//   bus      - sram_req_queue_if.slave (host request/response + controller side)
//   busy     - FIFO non-empty or a request in flight
// Optional build macro SRAM_REQ_STATS_EN adds:
//   wr_count, rd_count - issued write/read counters (16 bit, wrapping)
//   occupancy          - live FIFO entry count
//
// state   | meaning
// S_IDLE  | waiting for a queued request and controller ready
// S_ISSUE | mem strobe high for this single cycle
// S_WAIT  | write: one settle cycle; read: wait for read data
module sram_req_queue #(
  parameter int AW     = 18,
  parameter int DW     = 16,
  parameter int DEPTH  = 8,
  parameter int RD_LAT = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  sram_req_queue_if.slave        bus,
`ifdef SRAM_REQ_STATS_EN
  output logic [15:0]            wr_count,
  output logic [15:0]            rd_count,
  output logic [$clog2(DEPTH):0] occupancy,
`endif
  output logic                   busy
);

  localparam int IW = $clog2(DEPTH);
  localparam int EW = 1 + AW + DW;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        state;
  logic [IW:0]   wr_ptr;
  logic [IW:0]   rd_ptr;
  logic [EW-1:0] fifo_mem [DEPTH];
  logic [EW-1:0] head;
  logic [CW-1:0] cnt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign bus.req_ready = !full;
  assign push          = bus.req_valid && !full;
  assign pop           = (state == S_IDLE) && !empty && bus.sram_ready;
  assign head          = fifo_mem[rd_ptr[IW-1:0]];
  assign busy          = !empty || (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[IW-1:0]] <= {bus.req_rw, bus.req_addr, bus.req_wdata};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wr_ptr <= '0;
    else if (push) wr_ptr <= wr_ptr + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      rd_ptr        <= '0;
      cnt           <= '0;
      bus.mem       <= 1'b0;
      bus.rw        <= 1'b0;
      bus.addr      <= '0;
      bus.data_f2s  <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            bus.rw       <= head[EW-1];
            bus.addr     <= head[EW-2 -: AW];
            bus.data_f2s <= head[DW-1:0];
            rd_ptr       <= rd_ptr + 1'b1;
            bus.mem      <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          bus.mem <= 1'b0;
          cnt     <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (!bus.rw) begin
            state <= S_IDLE;
          end else if (cnt == CW'(RD_LAT - 1)) begin
            bus.rsp_rdata <= bus.sram_rdata;
            bus.rsp_valid <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SRAM_REQ_STATS_EN
  // Counted at the pop, so the new value is visible during the strobe cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_count <= '0;
      rd_count <= '0;
    end else if (pop) begin
      if (head[EW-1]) rd_count <= rd_count + 16'd1;
      else            wr_count <= wr_count + 16'd1;
    end
  end

  assign occupancy = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_sram_req_queue.sv
module tb_sram_req_queue;
  localparam int AW     = 18;
  localparam int DW     = 16;
  localparam int DEPTH  = 8;
  localparam int RD_LAT = 2;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef struct {
    int   cyc;
    req_t r;
  } iss_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
  } rsp_t;

  logic clk;
  logic reset_n;
  logic busy;
`ifdef SRAM_REQ_STATS_EN
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic [3:0]  occupancy;
`endif

  sram_req_queue_if #(.AW(AW), .DW(DW)) bif ();

  sram_req_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bif),
`ifdef SRAM_REQ_STATS_EN
    .wr_count (wr_count),
    .rd_count (rd_count),
    .occupancy(occupancy),
`endif
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_issued = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // One request served at a time; after a pop the server is unavailable for
  // 2 edges (write) or RD_LAT+1 edges (read); read data is taken on the last.
  int      cyc = 0;
  req_t    m_q[$];
  iss_t    exp_iss[$];
  rsp_t    exp_rsp[$];
  int      srv_left = 0;
  bit      cur_rd = 0;
  bit      m_acc;
  req_t    m_r;
  req_t    last_iss = '0;
  logic [DW-1:0] last_rsp = '0;
  int      m_wr = 0;
  int      m_rd = 0;

  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      m_q.delete();
      exp_iss.delete();
      exp_rsp.delete();
      srv_left = 0;
      cur_rd   = 0;
      last_iss = '0;
      last_rsp = '0;
      m_wr     = 0;
      m_rd     = 0;
    end else begin
      m_acc = bif.req_valid && (m_q.size() < DEPTH);
      if (srv_left > 0) begin
        srv_left--;
        if (srv_left == 0 && cur_rd) begin
          exp_rsp.push_back('{cyc, bif.sram_rdata});
          last_rsp = bif.sram_rdata;
        end
      end else if (m_q.size() > 0 && bif.sram_ready) begin
        m_r = m_q.pop_front();
        exp_iss.push_back('{cyc, m_r});
        last_iss = m_r;
        cur_rd   = m_r.rw;
        srv_left = m_r.rw ? RD_LAT + 1 : 2;
        if (m_r.rw) m_rd = (m_rd + 1) % 65536;
        else        m_wr = (m_wr + 1) % 65536;
      end
      if (m_acc) m_q.push_back({bif.req_rw, bif.req_addr, bif.req_wdata});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  iss_t mon_i;
  rsp_t mon_r;

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      chk("rst_mem",       32'(bif.mem),       32'd0);
      chk("rst_rw",        32'(bif.rw),        32'd0);
      chk("rst_addr",      32'(bif.addr),      32'd0);
      chk("rst_data_f2s",  32'(bif.data_f2s),  32'd0);
      chk("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", 32'(bif.rsp_rdata), 32'd0);
      chk("rst_busy",      32'(busy),          32'd0);
`ifdef SRAM_REQ_STATS_EN
      chk("rst_wr_count",  32'(wr_count),      32'd0);
      chk("rst_rd_count",  32'(rd_count),      32'd0);
      chk("rst_occupancy", 32'(occupancy),     32'd0);
`endif
    end else begin
      if (bif.mem) n_issued++;
      if (exp_iss.size() > 0 && exp_iss[0].cyc == cyc) begin
        mon_i = exp_iss.pop_front();
        chk("issue_mem",      32'(bif.mem),      32'd1);
        chk("issue_rw",       32'(bif.rw),       32'(mon_i.r.rw));
        chk("issue_addr",     32'(bif.addr),     32'(mon_i.r.addr));
        chk("issue_data_f2s", 32'(bif.data_f2s), 32'(mon_i.r.data));
      end else begin
        chk("no_mem", 32'(bif.mem), 32'd0);
      end
      if (exp_rsp.size() > 0 && exp_rsp[0].cyc == cyc) begin
        mon_r = exp_rsp.pop_front();
        chk("rsp_valid", 32'(bif.rsp_valid), 32'd1);
        chk("rsp_rdata", 32'(bif.rsp_rdata), 32'(mon_r.d));
      end else begin
        chk("no_rsp_valid", 32'(bif.rsp_valid), 32'd0);
      end
      chk("hold_rw",       32'(bif.rw),        32'(last_iss.rw));
      chk("hold_addr",     32'(bif.addr),      32'(last_iss.addr));
      chk("hold_data_f2s", 32'(bif.data_f2s),  32'(last_iss.data));
      chk("hold_rsp_rdata",32'(bif.rsp_rdata), 32'(last_rsp));
      chk("req_ready",     32'(bif.req_ready), 32'(m_q.size() < DEPTH));
      chk("busy",          32'(busy),          32'((m_q.size() > 0) || (srv_left > 0)));
`ifdef SRAM_REQ_STATS_EN
      chk("wr_count",      32'(wr_count),      32'(m_wr));
      chk("rd_count",      32'(rd_count),      32'(m_rd));
      chk("occupancy",     32'(occupancy),     32'(m_q.size()));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic rw, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic rdy, input logic [DW-1:0] rd);
    @(negedge clk);
    bif.req_valid  = v;
    bif.req_rw     = rw;
    bif.req_addr   = a;
    bif.req_wdata  = d;
    bif.sram_ready = rdy;
    bif.sram_rdata = rd;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    step(1'b0, 1'b0, '0, '0, 1'b1, DW'($urandom));
    while (busy && n < max_cyc) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, DW'($urandom));
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout busy=%0b required=0 after %0d cycles", busy, max_cyc);
    end
  endtask

  int base;

  initial begin
    reset_n        = 1'b0;
    bif.req_valid  = 1'b0;
    bif.req_rw     = 1'b0;
    bif.req_addr   = '0;
    bif.req_wdata  = '0;
    bif.sram_ready = 1'b0;
    bif.sram_rdata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b0, '0, '0, 1'b1, '0);
    chk("ready_after_reset", 32'(bif.req_ready), 32'd1);

    // single write
    step(1'b1, 1'b0, 18'h00A5, 16'hBEEF, 1'b1, '0);
    wait_idle(20);

    // single read, controller returns BEEF
    step(1'b1, 1'b1, 18'h00A5, 16'h1234, 1'b1, 16'hBEEF);
    repeat (6) step(1'b0, 1'b0, '0, '0, 1'b1, 16'hBEEF);
    chk("read_rdata_beef", 32'(bif.rsp_rdata), 32'h0000BEEF);
    wait_idle(20);

    // fill to full with controller not ready; ninth push is dropped
    step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    base = n_issued;
    for (int i = 0; i < 9; i++)
      step(1'b1, 1'(i % 2), AW'(100 + i), DW'(16'hA000 + i), 1'b0, DW'($urandom));
    step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    chk("full_req_ready", 32'(bif.req_ready), 32'd0);
    wait_idle(200);
    chk("drain_count", 32'(n_issued - base), 32'd8);

    // stall: two queued, controller busy for 5 cycles
    step(1'b1, 1'b0, 18'h00011, 16'h1111, 1'b0, '0);
    step(1'b1, 1'b1, 18'h00022, 16'h2222, 1'b0, '0);
    repeat (5) step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    wait_idle(50);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), AW'($urandom),
           DW'($urandom), 1'($urandom_range(0, 9) < 8), DW'($urandom));
    wait_idle(200);

    // reset in the middle of traffic
    step(1'b1, 1'b1, 18'h3FFFF, 16'h0F0F, 1'b1, 16'h5A5A);
    step(1'b1, 1'b1, 18'h00001, 16'hF0F0, 1'b1, 16'h5A5A);
    step(1'b1, 1'b0, 18'h00002, 16'h3333, 1'b1, 16'h5A5A);
    step(1'b0, 1'b0, '0, '0, 1'b1, 16'h5A5A);
    reset_n = 1'b0;
    repeat (2) step(1'b0, 1'b0, '0, '0, 1'b1, 16'h5A5A);
    reset_n = 1'b1;
    repeat (8) step(1'b0, 1'b0, '0, '0, 1'b1, 16'h5A5A);
    chk("busy_after_mid_reset", 32'(busy), 32'd0);

    // three writes and two reads
    step(1'b1, 1'b0, 18'h00100, 16'h0001, 1'b1, '0);
    step(1'b1, 1'b1, 18'h00101, 16'h0002, 1'b1, '0);
    step(1'b1, 1'b0, 18'h00102, 16'h0003, 1'b1, '0);
    step(1'b1, 1'b1, 18'h00103, 16'h0004, 1'b1, '0);
    step(1'b1, 1'b0, 18'h00104, 16'h0005, 1'b1, '0);
    wait_idle(100);
`ifdef SRAM_REQ_STATS_EN
    chk("stats_wr_count",  32'(wr_count),  32'd3);
    chk("stats_rd_count",  32'(rd_count),  32'd2);
    chk("stats_occupancy", 32'(occupancy), 32'd0);
`endif
    repeat (3) step(1'b0, 1'b0, '0, '0, 1'b1, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
